// File: rtl/clint_cmp_sequencer.sv
// Serialises per-requester 64-bit mtimecmp updates onto a 32-bit-half register port.
// The high word is parked at all-ones first so no spurious timer interrupt fires mid-update.
//
// state  | meaning
// IDLE   | waiting for a request, round-robin arbitration, ready pulse
// HI_MAX | write 0xFFFFFFFF to the upper mtimecmp word
// LO     | write the new lower word
// HI     | write the new upper word
// DONE   | one-cycle completion pulse with id and error flag
module clint_cmp_sequencer #(
  parameter int NR_REQ   = 2,
  parameter int NR_CORES = 1,
  parameter int HART_W   = 4,
  localparam int IDX_W   = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NR_REQ-1:0]              req_valid_i,
  output logic [NR_REQ-1:0]              req_ready_o,
  input  logic [NR_REQ-1:0][HART_W-1:0]  req_hart_i,
  input  logic [NR_REQ-1:0][63:0]        req_data_i,
  output logic                           reg_req_o,
  output logic [15:0]                    reg_addr_o,
  output logic [7:0]                     reg_be_o,
  output logic [63:0]                    reg_wdata_o,
  input  logic                           reg_gnt_i,
  output logic                           done_o,
  output logic [IDX_W-1:0]               done_id_o,
  output logic                           done_err_o
);

  localparam logic [31:0] NR_CORES_U = 32'(NR_CORES);

  typedef enum logic [2:0] {IDLE, HI_MAX, LO, HI, DONE} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [HART_W-1:0] hart_q;
  logic [63:0]       data_q;
  logic [IDX_W-1:0]  idx_q;
  logic              err_q;

  logic              any_valid, hi_found, accept, bad_hart;
  logic [IDX_W-1:0]  lo_idx, hi_idx, winner;
  logic [HART_W-1:0] sel_hart;
  logic [63:0]       sel_data;
  logic [15:0]       base_addr;

  // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    any_valid = 1'b0;
    hi_found  = 1'b0;
    lo_idx    = '0;
    hi_idx    = '0;
    for (int i = NR_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        any_valid = 1'b1;
        lo_idx    = IDX_W'(i);
        if (i >= int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

  assign sel_hart  = req_hart_i[winner];
  assign sel_data  = req_data_i[winner];
  assign bad_hart  = 32'(sel_hart) >= NR_CORES_U;
  assign accept    = rst_ni && (state_q == IDLE) && any_valid;
  assign rr_ptr_d  = (winner == IDX_W'(NR_REQ - 1)) ? '0 : winner + IDX_W'(1);
  assign base_addr = 16'h4000 + 16'(32'(hart_q) << 3);

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[winner] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      hart_q   <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            hart_q   <= sel_hart;
            data_q   <= sel_data;
            idx_q    <= winner;
            err_q    <= bad_hart;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= bad_hart ? DONE : HI_MAX;
          end
        end
        HI_MAX:  if (reg_gnt_i) state_q <= LO;
        LO:      if (reg_gnt_i) state_q <= HI;
        HI:      if (reg_gnt_i) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    reg_req_o   = 1'b0;
    reg_addr_o  = '0;
    reg_be_o    = '0;
    reg_wdata_o = '0;
    case (state_q)
      HI_MAX: begin
        reg_req_o   = 1'b1;
        reg_addr_o  = base_addr + 16'd4;
        reg_be_o    = 8'hF0;
        reg_wdata_o = {32'hFFFF_FFFF, 32'h0};
      end
      LO: begin
        reg_req_o   = 1'b1;
        reg_addr_o  = base_addr;
        reg_be_o    = 8'h0F;
        reg_wdata_o = {32'h0, data_q[31:0]};
      end
      HI: begin
        reg_req_o   = 1'b1;
        reg_addr_o  = base_addr + 16'd4;
        reg_be_o    = 8'hF0;
        reg_wdata_o = {data_q[63:32], 32'h0};
      end
      default: ;
    endcase
  end

  assign done_o     = (state_q == DONE);
  assign done_id_o  = done_o ? idx_q : '0;
  assign done_err_o = done_o & err_q;

endmodule

// File: tb/tb_clint_cmp_sequencer.sv
// Scoreboard bench for clint_cmp_sequencer: directed requests queue expected
// ready/write/done events; a negedge monitor pops and compares them.
module tb_clint_cmp_sequencer;
  localparam int NR_REQ = 2, NR_CORES = 1, HART_W = 4;

  logic                          clk_i = 1'b0;
  logic                          rst_ni = 1'b0;
  logic [NR_REQ-1:0]             req_valid;
  logic [NR_REQ-1:0]             req_ready;
  logic [NR_REQ-1:0][HART_W-1:0] req_hart;
  logic [NR_REQ-1:0][63:0]       req_data;
  logic                          reg_req;
  logic [15:0]                   reg_addr;
  logic [7:0]                    reg_be;
  logic [63:0]                   reg_wdata;
  logic                          reg_gnt;
  logic                          done;
  logic [0:0]                    done_id;
  logic                          done_err;

  clint_cmp_sequencer #(.NR_REQ(NR_REQ), .NR_CORES(NR_CORES), .HART_W(HART_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_hart_i(req_hart), .req_data_i(req_data),
    .reg_req_o(reg_req), .reg_addr_o(reg_addr), .reg_be_o(reg_be),
    .reg_wdata_o(reg_wdata), .reg_gnt_i(reg_gnt),
    .done_o(done), .done_id_o(done_id), .done_err_o(done_err)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {int id; int gap;} rdy_t;
  typedef struct {logic [15:0] addr; logic [7:0] be; logic [63:0] wd;} wr_t;
  typedef struct {int id; bit err; int lat;} dn_t;

  rdy_t rq[$];
  wr_t  wq[$];
  dn_t  dq[$];

  int checks = 0, errors = 0;
  int rdy_seen = 0, done_seen = 0, last_rdy = 0;
  bit prev_stall = 0;
  wr_t prev_wr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // mode 0: full sequence, mode 1: sequence cut by reset while in HI
  task automatic push_txn(input int id, input int hart, input logic [63:0] d,
                          input int lat, input int gap, input int mode);
    logic [15:0] base;
    base = 16'h4000 + 16'(hart * 8);
    rq.push_back('{id, gap});
    if (hart >= NR_CORES) begin
      dq.push_back('{id, 1'b1, 1});
    end else begin
      wq.push_back('{base + 16'd4, 8'hF0, 64'hFFFF_FFFF_0000_0000});
      wq.push_back('{base, 8'h0F, {32'h0, d[31:0]}});
      if (mode == 0) begin
        wq.push_back('{base + 16'd4, 8'hF0, {d[63:32], 32'h0}});
        dq.push_back('{id, 1'b0, lat});
      end
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_stall = 0;
    end else begin
      if (req_ready != '0) begin
        rdy_t r;
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL ready_unexpected got %b want none", req_ready);
        end else begin
          r = rq.pop_front();
          chk("ready_onehot", 64'(req_ready), 64'(2'b01 << r.id));
          if (r.gap != 0) chk("ready_gap", 64'(cyc - last_rdy), 64'(r.gap));
        end
        last_rdy = cyc;
        rdy_seen++;
      end
      if (reg_req) begin
        if (prev_stall) begin
          chk("stall_addr", 64'(reg_addr), 64'(prev_wr.addr));
          chk("stall_wdata", reg_wdata, prev_wr.wd);
        end
        if (reg_gnt) begin
          wr_t w;
          if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL write_unexpected got addr %h want none", reg_addr);
          end else begin
            w = wq.pop_front();
            chk("wr_addr", 64'(reg_addr), 64'(w.addr));
            chk("wr_be", 64'(reg_be), 64'(w.be));
            chk("wr_wdata", reg_wdata, w.wd);
          end
        end
        prev_stall = !reg_gnt;
        prev_wr = '{reg_addr, reg_be, reg_wdata};
      end else begin
        prev_stall = 0;
      end
      if (done) begin
        dn_t e;
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected got id %0d want none", done_id);
        end else begin
          e = dq.pop_front();
          chk("done_id", 64'(done_id), 64'(e.id));
          chk("done_err", 64'(done_err), 64'(e.err));
          chk("done_latency", 64'(cyc - last_rdy), 64'(e.lat));
        end
        done_seen++;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_reg_req"}, 64'(reg_req), 64'd0);
    chk({tag, "_addr"}, 64'(reg_addr), 64'd0);
    chk({tag, "_be"}, 64'(reg_be), 64'd0);
    chk({tag, "_wdata"}, reg_wdata, 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_done_id"}, 64'(done_id), 64'd0);
    chk({tag, "_done_err"}, 64'(done_err), 64'd0);
  endtask

  task automatic wait_ready_drop(input int id);
    bit seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk_i);
      seen = req_ready[id];
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ready_timeout id %0d got none want pulse", id);
    end
    @(posedge clk_i);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic wait_rdy(input int n);
    int k = 0;
    while (rdy_seen < n && k < 100) begin
      @(negedge clk_i); #1; k++;
    end
    if (rdy_seen < n) begin
      checks++; errors++;
      $display("FAIL ready_count_timeout got %0d want %0d", rdy_seen, n);
    end
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (done_seen < n && k < 100) begin
      @(negedge clk_i); #1; k++;
    end
    if (done_seen < n) begin
      checks++; errors++;
      $display("FAIL done_timeout got %0d want %0d", done_seen, n);
    end
  endtask

  initial begin
    req_valid = '0;
    req_hart  = '0;
    req_data  = '0;
    reg_gnt   = 1'b1;

    // contention from reset: both held valid
    req_valid   = 2'b11;
    req_data[0] = 64'h0000_00AA_0000_0011;
    req_data[1] = 64'h0000_00BB_0000_0022;
    repeat (3) @(posedge clk_i);
    #1 check_zero("reset");
    push_txn(0, 0, req_data[0], 4, 0, 0);
    push_txn(1, 0, req_data[1], 4, 5, 0);
    push_txn(0, 0, req_data[0], 4, 5, 0);
    push_txn(1, 0, req_data[1], 4, 5, 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    wait_rdy(4);
    @(posedge clk_i);
    #1 req_valid = '0;
    wait_done(4);

    // single request
    req_data[0] = 64'h0000_0001_0000_0100;
    push_txn(0, 0, req_data[0], 4, 0, 0);
    @(posedge clk_i);
    #1 req_valid[0] = 1'b1;
    wait_ready_drop(0);
    wait_done(5);

    // grant stall of three cycles in LO
    req_data[1] = 64'h1234_5678_9ABC_DEF0;
    push_txn(1, 0, req_data[1], 7, 0, 0);
    @(posedge clk_i);
    #1 req_valid[1] = 1'b1;
    wait_ready_drop(1);
    @(posedge clk_i);
    #1 reg_gnt = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 reg_gnt = 1'b1;
    wait_done(6);

    // bad hart
    req_hart[0] = 4'd2;
    push_txn(0, 2, req_data[0], 1, 0, 0);
    @(posedge clk_i);
    #1 req_valid[0] = 1'b1;
    wait_ready_drop(0);
    wait_done(7);

    // withdrawal of req1 while req0 is served
    req_hart[0] = 4'd0;
    req_data[0] = 64'hCAFE_0000_0000_BEEF;
    push_txn(0, 0, req_data[0], 4, 0, 0);
    @(posedge clk_i);
    #1 req_valid[0] = 1'b1;
    wait_ready_drop(0);
    req_valid[1] = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 req_valid[1] = 1'b0;
    wait_done(8);
    req_data[1] = 64'h0000_0003_0000_0007;
    push_txn(1, 0, req_data[1], 4, 0, 0);
    push_txn(0, 0, req_data[0], 4, 5, 0);
    @(posedge clk_i);
    #1 req_valid = 2'b11;
    wait_ready_drop(1);
    wait_ready_drop(0);
    wait_done(10);

    // reset while in HI
    req_data[0] = 64'h0000_0009_0000_0005;
    push_txn(0, 0, req_data[0], 4, 0, 1);
    @(posedge clk_i);
    #1 req_valid[0] = 1'b1;
    wait_ready_drop(0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1 check_zero("midrst");
    chk("midrst_writes_left", 64'(wq.size()), 64'd0);
    push_txn(0, 0, req_data[0], 4, 0, 0);
    push_txn(1, 0, req_data[1], 4, 5, 0);
    req_valid = 2'b11;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    wait_ready_drop(0);
    wait_ready_drop(1);
    wait_done(12);

    repeat (5) @(posedge clk_i);
    chk("done_count", 64'(done_seen), 64'd12);
    chk("ready_q_empty", 64'(rq.size()), 64'd0);
    chk("write_q_empty", 64'(wq.size()), 64'd0);
    chk("done_q_empty", 64'(dq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
